status_snapshot_regs: RTL and testbench

STATUS_SNAPSHOT_REGS -- requirements
Module: status_snapshot_regs

---
 rtl/status_snapshot_regs.sv | 146 ++++++++++++++
 tb/tb_status_snapshot_regs.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/status_snapshot_regs.sv
// status_snapshot_regs: per-channel sticky error flags, saturating edge
// counters and overflow flags, with a snapshot shadow of live status words
// and counters read back through a registered, pipelined read port.
// Optional: define STATUS_SNAP_TIMESTAMP_EN to add a free-running 48-bit
// cycle counter captured on snap_req and readable at 0x03/0x04.
module status_snapshot_regs #(
    parameter int unsigned N_CHAN = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CHAN-1:0]     chan_err,
    input  logic [N_CHAN*32-1:0]  live_status,
    input  logic                  snap_req,
    input  logic                  clr_req,
    input  logic                  rd_stb,
    input  logic [7:0]            rd_addr,
    output logic [31:0]           rd_data,
    output logic                  rd_ack,
    output logic [7:0]            snap_seq
);

    localparam logic [7:0]       NCHAN8  = 8'(N_CHAN);
    localparam logic [7:0]       CNTW8   = 8'(CNT_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_CHAN-1:0] err_q;
    logic [N_CHAN-1:0] edge_w;
    logic [N_CHAN-1:0] sticky_q, sticky_d;
    logic [N_CHAN-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q   [N_CHAN];
    logic [CNT_W-1:0]  cnt_d   [N_CHAN];
    logic [CNT_W-1:0]  cnt_upd [N_CHAN];
    logic [31:0]       shd_status_q [N_CHAN];
    logic [CNT_W-1:0]  shd_cnt_q    [N_CHAN];
    logic [7:0]        seq_q;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_ack_q;

`ifdef STATUS_SNAP_TIMESTAMP_EN
    logic [47:0] ts_q;
    logic [47:0] ts_snap_q;

    // Free-running cycle counter, captured on each snapshot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q      <= '0;
            ts_snap_q <= '0;
        end else begin
            ts_q <= ts_q + 48'd1;
            if (snap_req) ts_snap_q <= ts_q;
        end
    end
`endif

    // Error edge detection, sticky/overflow flags and counter next-state.
    // cnt_upd is the counter after this cycle's edge but before any clear,
    // so a snapshot coincident with a clear sees pre-clear values.
    always_comb begin
        edge_w   = chan_err & ~err_q;
        sticky_d = (clr_req ? '0 : sticky_q) | chan_err;
        ovf_d    = clr_req ? '0 : ovf_q;
        for (int unsigned i = 0; i < N_CHAN; i++) begin
            cnt_upd[i] = cnt_q[i];
            if (edge_w[i]) begin
                if (&cnt_q[i]) begin
                    if (!clr_req) ovf_d[i] = 1'b1;
                end else begin
                    cnt_upd[i] = cnt_q[i] + CNT_ONE;
                end
            end
            cnt_d[i] = clr_req ? (edge_w[i] ? CNT_ONE : '0) : cnt_upd[i];
        end
    end

    // Error tracking state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q    <= '0;
            sticky_q <= '0;
            ovf_q    <= '0;
            for (int unsigned i = 0; i < N_CHAN; i++) cnt_q[i] <= '0;
        end else begin
            err_q    <= chan_err;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
            for (int unsigned i = 0; i < N_CHAN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Snapshot shadow registers and sequence number
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_q <= '0;
            for (int unsigned i = 0; i < N_CHAN; i++) begin
                shd_status_q[i] <= '0;
                shd_cnt_q[i]    <= '0;
            end
        end else if (snap_req) begin
            seq_q <= seq_q + 8'd1;
            for (int unsigned i = 0; i < N_CHAN; i++) begin
                shd_status_q[i] <= live_status[32*i +: 32];
                shd_cnt_q[i]    <= cnt_upd[i];
            end
        end
    end

    // Read address decode; rd_data holds when no read is issued
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_stb) begin
            rd_data_d = '0;
            case (rd_addr)
                8'h00: rd_data_d = {8'hA5, NCHAN8, CNTW8, seq_q};
                8'h01: rd_data_d[N_CHAN-1:0] = sticky_q;
                8'h02: rd_data_d[N_CHAN-1:0] = ovf_q;
`ifdef STATUS_SNAP_TIMESTAMP_EN
                8'h03: rd_data_d = ts_snap_q[31:0];
                8'h04: rd_data_d = {16'h0, ts_snap_q[47:32]};
`endif
                default: begin
                    for (int unsigned i = 0; i < N_CHAN; i++) begin
                        if (rd_addr == 8'(32'h10 + i)) rd_data_d = shd_status_q[i];
                        if (rd_addr == 8'(32'h20 + i)) rd_data_d[CNT_W-1:0] = shd_cnt_q[i];
                    end
                end
            endcase
        end
    end

    // Registered read response, one cycle after each strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_stb;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_ack   = rd_ack_q;
    assign snap_seq = seq_q;

endmodule

// File: tb/tb_status_snapshot_regs.sv
// Directed bench for status_snapshot_regs: a default instance plus a
// CNT_W=8 instance sharing all inputs; read expectations are queued when a
// read is issued and checked when its acknowledge cycle arrives.
module tb_status_snapshot_regs;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   chan_err = '0;
    logic [N*32-1:0] live_status = '0;
    logic           snap_req = 1'b0;
    logic           clr_req = 1'b0;
    logic           rd_stb = 1'b0;
    logic [7:0]     rd_addr = '0;
    logic [31:0]    rd_data, rd_data8;
    logic           rd_ack, rd_ack8;
    logic [7:0]     snap_seq, snap_seq8;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic [31:0] exp8;
    } rd_item_t;

    rd_item_t        exp_q[$];
    int              n_assert = 0;
    int              n_fail = 0;
    logic [31:0]     last_exp = '0;
    logic [31:0]     last_exp8 = '0;
    int unsigned     exp_seq = 0;
    longint unsigned edges = 0;
    logic [31:0]     ts_exp;
`ifdef STATUS_SNAP_TIMESTAMP_EN
    longint unsigned ts_model = 0;
`endif

    status_snapshot_regs dut (
        .clk(clk), .reset_n(reset_n), .chan_err(chan_err), .live_status(live_status),
        .snap_req(snap_req), .clr_req(clr_req), .rd_stb(rd_stb), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_ack(rd_ack), .snap_seq(snap_seq)
    );

    status_snapshot_regs #(.N_CHAN(5), .CNT_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .chan_err(chan_err), .live_status(live_status),
        .snap_req(snap_req), .clr_req(clr_req), .rd_stb(rd_stb), .rd_addr(rd_addr),
        .rd_data(rd_data8), .rd_ack(rd_ack8), .snap_seq(snap_seq8)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue_read(input logic [7:0] a, input logic [31:0] e,
                              input logic [31:0] e8, input string tag);
        rd_item_t it;
        it.tag  = tag;
        it.exp  = e;
        it.exp8 = e8;
        rd_stb  = 1'b1;
        rd_addr = a;
        exp_q.push_back(it);
    endtask

    // One clock: update model for pulses, advance, clear pulses, check outputs
    task automatic tick();
        rd_item_t it;
        logic     stb_v;
        stb_v = rd_stb;
        if (snap_req) begin
`ifdef STATUS_SNAP_TIMESTAMP_EN
            ts_model = edges;
`endif
            exp_seq = (exp_seq + 1) % 256;
        end
        edges++;
        @(posedge clk);
        #1;
        rd_stb   = 1'b0;
        snap_req = 1'b0;
        clr_req  = 1'b0;
        if (stb_v) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL sb_underflow: observed empty queue expected an entry");
            end else begin
                it = exp_q.pop_front();
                chk({31'b0, rd_ack},  32'd1, {"ack_", it.tag});
                chk({31'b0, rd_ack8}, 32'd1, {"ack8_", it.tag});
                chk(rd_data,  it.exp,  it.tag);
                chk(rd_data8, it.exp8, {it.tag, "_w8"});
                last_exp  = it.exp;
                last_exp8 = it.exp8;
            end
        end else begin
            chk({31'b0, rd_ack},  32'd0, "idle_ack");
            chk({31'b0, rd_ack8}, 32'd0, "idle_ack8");
            chk(rd_data,  last_exp,  "hold");
            chk(rd_data8, last_exp8, "hold8");
        end
        chk({24'b0, snap_seq},  exp_seq, "snap_seq");
        chk({24'b0, snap_seq8}, exp_seq, "snap_seq8");
    endtask

    initial begin
        // Reset state
        #1;
        chk(rd_data, 32'h0, "rst_rd_data");
        chk({31'b0, rd_ack}, 32'h0, "rst_rd_ack");
        chk({24'b0, snap_seq}, 32'h0, "rst_snap_seq");
        repeat (3) @(posedge clk);
        #1;
        chk(rd_data8, 32'h0, "rst_rd_data8");
        reset_n = 1'b1;
        edges = 0;

        // Back-to-back reads straight after reset
        issue_read(8'h00, 32'hA5051000, 32'hA5050800, "hdr0"); tick();
        issue_read(8'h01, 32'h0, 32'h0, "sticky0");            tick();
        issue_read(8'h22, 32'h0, 32'h0, "cnt2_0");             tick();
        issue_read(8'h40, 32'h0, 32'h0, "unmapped40");         tick();
        tick();

        // Channel 2: high 3 cycles, low, high again -> 2 edges
        chan_err[2] = 1'b1; repeat (3) tick();
        chan_err[2] = 1'b0; tick();
        chan_err[2] = 1'b1; tick();
        chan_err[2] = 1'b0; tick();
        snap_req = 1'b1; tick();
        issue_read(8'h22, 32'h2, 32'h2, "cnt2_edges");         tick();
        issue_read(8'h01, 32'h4, 32'h4, "sticky2");            tick();
        issue_read(8'h00, 32'hA5051001, 32'hA5050801, "hdr1"); tick();

        // 256 edges on channel 0: saturates the 8-bit instance
        for (int k = 0; k < 256; k++) begin
            chan_err[0] = 1'b1; tick();
            chan_err[0] = 1'b0; tick();
        end
        snap_req = 1'b1; tick();
        issue_read(8'h20, 32'h100, 32'hFF, "cnt0_sat");        tick();
        issue_read(8'h02, 32'h0, 32'h1, "ovf0");               tick();
        issue_read(8'h01, 32'h5, 32'h5, "sticky02");           tick();

        // Snapshot and clear together: shadow keeps pre-clear counts
        snap_req = 1'b1; clr_req = 1'b1; tick();
        issue_read(8'h20, 32'h100, 32'hFF, "snapclr_cnt0");    tick();
        issue_read(8'h22, 32'h2, 32'h2, "snapclr_cnt2");       tick();
        issue_read(8'h01, 32'h0, 32'h0, "clr_sticky");         tick();
        issue_read(8'h02, 32'h0, 32'h0, "clr_ovf");            tick();

        // Clear coincident with a rising edge on channel 1
        chan_err[1] = 1'b1; clr_req = 1'b1; tick();
        snap_req = 1'b1; tick();
        issue_read(8'h21, 32'h1, 32'h1, "clr_edge_cnt1");      tick();
        issue_read(8'h01, 32'h2, 32'h2, "clr_edge_sticky1");   tick();
        issue_read(8'h20, 32'h0, 32'h0, "clr_cnt0");           tick();
        // Clear while channel 1 held high (no edge)
        clr_req = 1'b1; tick();
        chan_err[1] = 1'b0;
        snap_req = 1'b1; tick();
        issue_read(8'h21, 32'h0, 32'h0, "clr_level_cnt1");     tick();
        issue_read(8'h01, 32'h2, 32'h2, "clr_level_sticky1");  tick();

        // Shadow status capture, read coincident with snapshot
        live_status[0 +: 32]   = 32'h11111111;
        live_status[128 +: 32] = 32'hCAFE0004;
        snap_req = 1'b1; tick();
        live_status[128 +: 32] = 32'hDEADBEEF;
        issue_read(8'h14, 32'hCAFE0004, 32'hCAFE0004, "shd_ch4");   tick();
        issue_read(8'h10, 32'h11111111, 32'h11111111, "shd_ch0");   tick();
        issue_read(8'h14, 32'hCAFE0004, 32'hCAFE0004, "rd_at_snap");
        snap_req = 1'b1; tick();
        issue_read(8'h14, 32'hDEADBEEF, 32'hDEADBEEF, "shd_ch4_new"); tick();
        issue_read(8'h25, 32'h0, 32'h0, "cnt_ch5_oor");             tick();
        issue_read(8'h0F, 32'h0, 32'h0, "unmapped0f");              tick();

        // 256 snapshots: sequence wraps back to the same value
        for (int k = 0; k < 256; k++) begin
            snap_req = 1'b1; tick();
        end

        // Three consecutive reads: header, out-of-range channel, timestamp
`ifdef STATUS_SNAP_TIMESTAMP_EN
        ts_exp = ts_model[31:0];
`else
        ts_exp = 32'h0;
`endif
        issue_read(8'h00, 32'hA5051007, 32'hA5050807, "b2b_hdr"); tick();
        issue_read(8'h15, 32'h0, 32'h0, "b2b_ch5");               tick();
        issue_read(8'h03, ts_exp, ts_exp, "b2b_ts_lo");           tick();
        issue_read(8'h04, 32'h0, 32'h0, "ts_hi");                 tick();
        tick();

        // Reset asserted mid-read: outputs clear immediately, read dropped
        issue_read(8'h00, 32'hA5051007, 32'hA5050807, "pre_rst_hdr"); tick();
        rd_stb  = 1'b1;
        rd_addr = 8'h01;
        #4;
        reset_n = 1'b0;
        #1;
        chk(rd_data, 32'h0, "async_rst_rd_data");
        chk({31'b0, rd_ack}, 32'h0, "async_rst_rd_ack");
        chk({24'b0, snap_seq}, 32'h0, "async_rst_snap_seq");
        chk(rd_data8, 32'h0, "async_rst_rd_data8");
        rd_stb   = 1'b0;
        chan_err = 5'b01000;
        @(posedge clk);
        #1;
        chk({31'b0, rd_ack}, 32'h0, "dropped_rd_ack");
        chk(rd_data, 32'h0, "dropped_rd_data");
        reset_n   = 1'b1;
        edges     = 0;
        exp_seq   = 0;
        last_exp  = '0;
        last_exp8 = '0;

        // First cycle after reset with chan_err[3]=1 produces an edge
        issue_read(8'h01, 32'h0, 32'h0, "post_rst_sticky");    tick();
        snap_req = 1'b1; tick();
        issue_read(8'h23, 32'h1, 32'h1, "post_rst_cnt3");      tick();
        issue_read(8'h01, 32'h8, 32'h8, "post_rst_sticky3");   tick();
        issue_read(8'h20, 32'h0, 32'h0, "post_rst_cnt0");      tick();
        issue_read(8'h00, 32'hA5051001, 32'hA5050801, "post_rst_hdr"); tick();
        chan_err = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
